load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the execute stage and the writeback multiplexer. It takes a LOAD or STORE decoded in execute, checks alignment, runs a request/ready handshake with data memory, and drives byte enables and replicated store data. For loads it returns a lane-extracted, sign- or zero-extended 32-bit word that the writeback mux selects for the `LOAD` opcode. It stalls the pipeline while a memory transfer is in flight.

## Interface
- `MEM_TIMEOUT`, default 255: maximum cycles in REQ waiting for `mem_ready` before the access is aborted with a fault; must be ≥1.
- `sysclk` in 1: the only clock; all state updates on its rising edge.
- `cpu_resetn` in 1: reset, synchronous and active-low.
- `start` in 1: execute presents a memory instruction this cycle.
- `opcode` in 7: `LOAD` or `STORE`; any other value with `start`=1 is ignored.
- `funct3` in 3: access size and sign, using RV32I encoding.
- `addr` in 32: effective address from the ALU.
- `store_data` in 32: rs2 value.
- `mem_req` out 1: request valid toward data memory.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte-lane enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: memory accepts or completes the transfer this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready`=1.
- `load_data` out 32: extended load result, feeds the writeback mux.
- `stall` out 1: the pipeline must hold.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: qualifies `done`; signals a misaligned access, illegal funct3, or timeout.

## Operation
- States are IDLE, REQ and DONE.
- **IDLE**
  - A qualifying `start` latches `opcode`, `funct3`, `addr` and `store_data`.
  - If the access is legal, go to REQ.
  - Otherwise go to DONE with the fault latched and no memory access.
- **REQ**
  - `mem_req`=1, and all `mem_*` outputs are driven from the latched registers and stay stable.
  - On `mem_ready`=1, capture `mem_rdata` (loads only) and go to DONE.
  - If the timeout counter reaches `MEM_TIMEOUT`, go to DONE with the fault set.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
  - A new `start` is not accepted in DONE.
- **Legality**
  - funct3 must be one of LB/LBU/SB (000/100), LH/LHU/SH (001/101), or LW/SW (010).
  - Illegal cases: 011, 110, 111, and any funct3 other than 000/001/010 on a store.
  - Misaligned: a halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0.
- **Byte enables**
  - Byte: `4'b0001<<addr[1:0]`.
  - Half: `addr[1]` ? 1100 : 0011.
  - Word: 1111.
- **Store data**
  - Byte: `{4{store_data[7:0]}}`.
  - Half: `{2{store_data[15:0]}}`.
  - Word: `store_data`.
- **Load result**
  - Select the byte at `8*addr[1:0]` or the half at `16*addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - `load_data` is registered and holds its value until the next successful load.
  - Stores and faulted accesses leave `load_data` unchanged.
- **Stall**
  - `stall` = (state==REQ) | (state==IDLE & `start` & `opcode`∈{LOAD,STORE}).
  - `stall` is 0 in DONE, so writeback consumes `load_data` in that cycle.

## Timing
- **Reset values:** state IDLE; `mem_req`, `mem_we`, `done`, `fault` and `stall` 0; `mem_be` 0; `mem_addr`, `mem_wdata` and `load_data` all 32'h0; timeout counter 0.
- **Minimum latency:** `start` at cycle T, `mem_req` at T+1, `mem_ready` at T+1, `done` at T+2.
  - Each extra wait cycle adds one cycle.
- **Faulted access without memory:** `start` at T, `done` and `fault` at T+1, and `mem_req` never rises.
- **Timeout counter**
  - Clears on entry to REQ and increments each REQ cycle with `mem_ready`=0.
  - At `MEM_TIMEOUT`, `mem_req` drops on the next edge and no transfer is recorded.
- **Ready and timeout in the same cycle:** ready wins, with no fault.
- **`start` outside IDLE:** ignored; the execute stage holds it under `stall`.
- **Reset mid-REQ:** `mem_req` is 0 on the next edge and nothing is written to `load_data`. Data memory must tolerate an abandoned request.

## Structure
- `define.vh` gains shared funct3 constants `LB/LH/LW/LBU/LHU/SB/SH/SW`, alongside the existing `LOAD`/`STORE` opcodes.
- State encodings stay local to the module.
- One combinational sub-module, `load_align`, takes (`funct3`, `addr[1:0]`, `mem_rdata`) and returns the 32-bit extended result.
  - It is reused by any future cache fill path.

## Test plan
- **LW:** LW `addr`=0x100 with `mem_ready` tied 1 and `mem_rdata`=0xDEADBEEF → `mem_be`=1111, `done` at T+2, `load_data`=0xDEADBEEF, `stall` high for T..T+1 only.
- **LB/LBU:** LB `addr`=0x103 with `mem_rdata`=0x80xxxxxx → `mem_be`=1000, `load_data`=0xFFFFFF80; the same access as LBU → 0x00000080.
- **SH with wait states:** SH `addr`=0x22, `store_data`=0x1234ABCD, `mem_ready` delayed 3 cycles → `mem_req` held 4 cycles, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `load_data` unchanged.
- **Misaligned and illegal:** LW `addr`=0x101 → no `mem_req`, `done`=`fault`=1 at T+1; funct3=011 on LOAD behaves the same.
- **Timeout:** `MEM_TIMEOUT`=4 with `mem_ready` stuck 0 → `mem_req` for 4 cycles, then `done`=`fault`=1; `cpu_resetn` low mid-REQ → `mem_req` 0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared opcodes, funct3 encodings and lane helpers for the load/store unit
// and any future cache fill path.
package load_store_unit_pkg;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Stores have no unsigned variants, so only the low three codes are legal for them.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (f3)
      LB:      ok = 1'b1;
      LH:      ok = ~addr_lo[0];
      LW:      ok = (addr_lo == 2'b00);
      LBU:     ok = ~is_store;
      LHU:     ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (addr_lo)
      2'b00:   sel_byte = mem_rdata[7:0];
      2'b01:   sel_byte = mem_rdata[15:8];
      2'b10:   sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3)
      LB:      result = {{24{sel_byte[7]}}, sel_byte};
      LBU:     result = {24'h0, sel_byte};
      LH:      result = {{16{sel_half[15]}}, sel_half};
      LHU:     result = {16'h0, sel_half};
      default: result = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: alignment check, memory request/ready handshake,
// lane steering for stores and extended load results for writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        sysclk,
  input  logic        cpu_resetn,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        fault
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    addr_lo_q;
  logic          store_q;
  logic          fault_q;
  logic [31:0]   align_data;
  logic          accept, legal, timed_out;

  assign accept    = (state == IDLE) && start && ((opcode == LOAD) || (opcode == STORE));
  assign legal     = access_ok(opcode == STORE, funct3, addr[1:0]);
  // Ready in the final allowed cycle still completes the transfer cleanly.
  assign timed_out = (state == REQ) && !mem_ready && (wait_cnt == WAIT_LAST);

  load_align u_align (
    .funct3    (funct3_q),
    .addr_lo   (addr_lo_q),
    .mem_rdata (mem_rdata),
    .result    (align_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = legal ? REQ : DONE;
      REQ:     if (mem_ready || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    mem_req = (state == REQ);
    mem_we  = (state == REQ) && store_q;
    done    = (state == DONE);
    fault   = (state == DONE) && fault_q;
    stall   = (state == REQ) || accept;
  end

  always_ff @(posedge sysclk) begin
    if (!cpu_resetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      store_q   <= 1'b0;
      fault_q   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      load_data <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        funct3_q  <= funct3;
        addr_lo_q <= addr[1:0];
        store_q   <= (opcode == STORE);
        fault_q   <= !legal;
        wait_cnt  <= '0;
        if (legal) begin
          mem_addr  <= {addr[31:2], 2'b00};
          mem_be    <= byte_enables(funct3[1:0], addr[1:0]);
          mem_wdata <= store_lanes(funct3[1:0], store_data);
        end
      end
      if (state == REQ) begin
        if (mem_ready && !store_q) load_data <= align_data;
        if (timed_out) fault_q <= 1'b1;
        else if (!mem_ready) wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions against a byte/size arithmetic reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TO = 4;

  logic        sysclk = 1'b0;
  logic        cpu_resetn;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        stall, done, fault;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] refLoad = 32'h0;

  load_store_unit #(.MEM_TIMEOUT(TO)) dut (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .start      (start),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .load_data  (load_data),
    .stall      (stall),
    .done       (done),
    .fault      (fault)
  );

  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Legal when the size exists, unsigned forms are loads of less than a word, and addr is size-aligned.
  function automatic bit refLegal(input bit isStore, input logic [2:0] f3, input logic [31:0] a);
    int size = accessSize(f3);
    if (f3[1:0] == 2'b11) return 0;
    if (f3[2] && (isStore || size == 4)) return 0;
    return (a % size) == 0;
  endfunction

  function automatic logic [3:0] refBe(input logic [2:0] f3, input logic [31:0] a);
    int mask = ((1 << accessSize(f3)) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] d);
    int size = accessSize(f3);
    if (size == 1) return (d & 32'hFF) * 32'h01010101;
    if (size == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] refLoadValue(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
    int size = accessSize(f3);
    logic [31:0] mask, val;
    if (size == 4) return rd;
    mask = (size == 1) ? 32'hFF : 32'hFFFF;
    val  = (rd >> (8 * (a % 4))) & mask;
    if (!f3[2] && ((val & ((mask + 1) >> 1)) != 0)) val = val | ~mask;
    return val;
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] rd, input int waits,
                               input bit startInDone);
    bit isMem   = (op == LOAD) || (op == STORE);
    bit isStore = (op == STORE);
    bit timeout;
    int reqCycles;
    @(negedge sysclk);
    start = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = sd;
    mem_ready = 1'b0; mem_rdata = rd;
    #1 checkOutput("stall_at_start", stall, isMem);
    @(negedge sysclk);
    start = 1'b0;
    #1;
    if (!isMem) begin
      checkOutput("ignored_req", mem_req, 0);
      checkOutput("ignored_done", done, 0);
      checkOutput("ignored_stall", stall, 0);
      return;
    end
    if (!refLegal(isStore, f3, a)) begin
      checkOutput("bad_done", done, 1);
      checkOutput("bad_fault", fault, 1);
      checkOutput("bad_req", mem_req, 0);
      checkOutput("bad_stall", stall, 0);
      checkOutput("bad_load_data", load_data, refLoad);
    end else begin
      timeout   = (waits >= TO);
      reqCycles = timeout ? TO : waits + 1;
      for (int k = 0; k < reqCycles; k++) begin
        mem_ready = (k == waits);
        #1;
        checkOutput("req", mem_req, 1);
        checkOutput("req_we", mem_we, isStore);
        checkOutput("req_addr", mem_addr, {a[31:2], 2'b00});
        checkOutput("req_be", mem_be, refBe(f3, a));
        if (isStore) checkOutput("req_wdata", mem_wdata, refWdata(f3, sd));
        checkOutput("req_stall", stall, 1);
        checkOutput("req_done", done, 0);
        @(negedge sysclk);
      end
      mem_ready = 1'b0;
      if (!timeout && !isStore) refLoad = refLoadValue(f3, a, rd);
      #1;
      checkOutput("done", done, 1);
      checkOutput("done_fault", fault, timeout);
      checkOutput("done_req", mem_req, 0);
      checkOutput("done_stall", stall, 0);
      checkOutput("done_load_data", load_data, refLoad);
    end
    if (startInDone) begin
      start = 1'b1; opcode = LOAD; funct3 = LW; addr = 32'h0;
    end
    @(negedge sysclk);
    start = 1'b0;
    #1;
    checkOutput("idle_done", done, 0);
    checkOutput("idle_req", mem_req, 0);
    checkOutput("idle_stall", stall, 0);
  endtask

  initial begin
    cpu_resetn = 1'b0; start = 1'b0; opcode = 7'h0; funct3 = 3'h0; addr = 32'h0;
    store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge sysclk);
    #1;
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_be", mem_be, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_load_data", load_data, 0);
    cpu_resetn = 1'b1;

    applyStimulus(LOAD, LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    checkOutput("lw_value", load_data, 32'hDEADBEEF);
    applyStimulus(LOAD, LB, 32'h103, 32'h0, 32'h80123456, 0, 0);
    checkOutput("lb_value", load_data, 32'hFFFFFF80);
    applyStimulus(LOAD, LBU, 32'h103, 32'h0, 32'h80123456, 0, 0);
    checkOutput("lbu_value", load_data, 32'h00000080);
    applyStimulus(STORE, SH, 32'h22, 32'h1234ABCD, 32'h0, 3, 0);
    checkOutput("sh_keeps_load", load_data, 32'h00000080);
    applyStimulus(LOAD, LW, 32'h101, 32'h0, 32'h0, 0, 0);
    applyStimulus(LOAD, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    applyStimulus(LOAD, LW, 32'h104, 32'h0, 32'h11111111, 10, 0);
    applyStimulus(LOAD, LH, 32'h2, 32'h0, 32'h8001_7FFF, 1, 1);
    checkOutput("lh_value", load_data, 32'hFFFF8001);
    applyStimulus(7'b0110011, LW, 32'h0, 32'h0, 32'h0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 9);
      logic [6:0] op = (r < 5) ? LOAD : (r < 9) ? STORE : 7'b0010011;
      applyStimulus(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                    $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    applyStimulus(LOAD, LW, 32'h300, 32'h0, 32'hCAFEF00D, 0, 0);
    @(negedge sysclk);
    start = 1'b1; opcode = LOAD; funct3 = LW; addr = 32'h200; mem_rdata = 32'h12345678;
    @(negedge sysclk);
    start = 1'b0;
    #1 checkOutput("midreq_req", mem_req, 1);
    cpu_resetn = 1'b0; mem_ready = 1'b1;
    @(negedge sysclk);
    #1;
    refLoad = 32'h0;
    checkOutput("midrst_req", mem_req, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_fault", fault, 0);
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_be", mem_be, 0);
    checkOutput("midrst_addr", mem_addr, 0);
    checkOutput("midrst_wdata", mem_wdata, 0);
    checkOutput("midrst_load_data", load_data, refLoad);
    cpu_resetn = 1'b1; mem_ready = 1'b0;
    @(negedge sysclk);
    #1 checkOutput("post_rst_req", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
